// File: rtl/uart_pkg.sv
// Purpose: shared UART definitions (FSM state encoding, default framing constants, parity helper).
// Latency: n/a (types, constants and a combinational function only).
// Backpressure: n/a.
package uart_pkg;

    // Transmit/receive frame sequencing states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;

    // Parity over an already-masked data byte: even parity unless odd is set.
    // Shared with the receiver so both ends agree on the definition.
    function automatic logic uart_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_baud_gen.sv
// Purpose: free-running bit-period counter (0..CLKS_PER_BIT-1) with a synchronous clear.
// Latency: bit_tick_o is combinational from the counter; clear takes effect at the next edge.
// Backpressure: none; the counter never stalls.
// Ports: clka_i clock, reset_i sync active-high reset, clear_i restart the bit period,
//        bit_tick_o high in the last-but-one cycle of every bit period.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clka_i,
    input  logic reset_i,
    input  logic clear_i,
    output logic bit_tick_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    // The serializer's line register follows its state register by one edge,
    // so the state must move one cycle ahead of the visible bit boundary.
    localparam logic [CW-1:0] CNT_TICK = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear_i || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clka_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick_o = (cnt_q == CNT_TICK);

endmodule

// File: rtl/uart_tx_serializer.sv
// Purpose: UART transmitter; frames a byte as start, LSB-first data, optional parity, stop.
// Latency: line drops 1 cycle after accept; tx_done pulses in the last cycle of the frame.
// Backpressure: tx_ready only in IDLE; tx_start while busy is ignored (no queuing).
// Ports: clka clock, reset sync active-high; tx_start/tx_data/tx_ready request handshake;
//        tx_serial line (idles high); tx_busy framing; tx_done frame-complete pulse;
//        tx_out last accepted byte (masked to DATA_BITS).
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clka,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [7:0] tx_out
);

    localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    uart_state_e state_q;
    logic [7:0]  shift_q;
    logic [7:0]  out_q;
    logic [2:0]  bit_cnt_q;
    logic        parity_q;
    logic        serial_q;
    logic        busy_q;
    logic        done_q;

    logic        accept;
    logic        bit_tick;
    logic [7:0]  data_masked;

    assign tx_ready    = (state_q == IDLE);
    assign accept      = tx_start && tx_ready;
    assign data_masked = tx_data & DATA_MASK;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clka_i     (clka),
        .reset_i    (reset),
        .clear_i    (accept),
        .bit_tick_o (bit_tick)
    );

    // tx_serial is driven from the current state, so it trails the state
    // register by one edge; the accept edge forces the start bit directly
    // to keep request-to-line latency at one cycle. Leaving STOP one cycle
    // early lets tx_done/tx_ready coincide with the last stop-bit cycle, so
    // a back-to-back start bit follows with no idle gap.
    always_ff @(posedge clka) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            out_q     <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            serial_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    serial_q <= 1'b1;
                    if (accept) begin
                        shift_q   <= data_masked;
                        out_q     <= data_masked;
                        parity_q  <= uart_parity(data_masked, PARITY_ODD != 0);
                        bit_cnt_q <= '0;
                        serial_q  <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= START;
                    end
                end
                START: begin
                    serial_q <= 1'b0;
                    if (bit_tick) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    serial_q <= shift_q[0];
                    if (bit_tick) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            state_q   <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    serial_q <= parity_q;
                    if (bit_tick) begin
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    serial_q <= 1'b1;
                    if (bit_tick) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    serial_q <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign tx_serial = serial_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;
    assign tx_out    = out_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Purpose: directed self-checking bench for uart_tx_serializer across four framing configs.
// Latency: checks line value every cycle against hand-written frame bit strings.
// Backpressure: exercises busy-ignore, back-to-back accept in the tx_done cycle, and mid-frame reset.
module tb_uart_tx_serializer;

    localparam int CPB = 16;

    logic       clka = 1'b0;
    logic       reset;
    logic       start  [4];
    logic [7:0] data   [4];
    logic       ready  [4];
    logic       serial [4];
    logic       busy   [4];
    logic       done   [4];
    logic [7:0] out    [4];

    int n_vec = 0;
    int n_err = 0;

    initial forever #5 clka = ~clka;

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 5N1
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
        .clka(clka), .reset(reset), .tx_start(start[0]), .tx_data(data[0]), .tx_ready(ready[0]),
        .tx_serial(serial[0]), .tx_busy(busy[0]), .tx_done(done[0]), .tx_out(out[0]));
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .clka(clka), .reset(reset), .tx_start(start[1]), .tx_data(data[1]), .tx_ready(ready[1]),
        .tx_serial(serial[1]), .tx_busy(busy[1]), .tx_done(done[1]), .tx_out(out[1]));
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
        .clka(clka), .reset(reset), .tx_start(start[2]), .tx_data(data[2]), .tx_ready(ready[2]),
        .tx_serial(serial[2]), .tx_busy(busy[2]), .tx_done(done[2]), .tx_out(out[2]));
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0)) u_dut3 (
        .clka(clka), .reset(reset), .tx_start(start[3]), .tx_data(data[3]), .tx_ready(ready[3]),
        .tx_serial(serial[3]), .tx_busy(busy[3]), .tx_done(done[3]), .tx_out(out[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Sends one frame on DUT id, starting at a negedge where the DUT should be ready.
    // seq lists the expected line bits, one character per bit period.
    // Returns at the negedge of the tx_done cycle so a following call is back-to-back.
    task automatic send(input int id, input logic [7:0] d, input string seq, input logic [7:0] exp_out,
                        input bit chain, input logic [7:0] next_d,
                        input int poke_at, input logic [7:0] poke_d, input int abort_at);
        int  f;
        byte c;
        f = seq.len() * CPB;
        chk("ready_before_accept", 32'(ready[id]), 32'd1);
        start[id] = 1'b1;
        data[id]  = d;
        @(posedge clka);
        for (int n = 1; n <= f; n++) begin
            @(negedge clka);
            if (n == 1) begin
                start[id] = chain;
                if (chain) data[id] = next_d;
                chk("busy_first", 32'(busy[id]), 32'd1);
                chk("ready_first", 32'(ready[id]), 32'd0);
                chk("out_first", 32'(out[id]), 32'(exp_out));
            end
            if (poke_at > 0 && n == poke_at) begin
                start[id] = 1'b1;
                data[id]  = poke_d;
            end
            if (poke_at > 0 && n == poke_at + 1) start[id] = 1'b0;
            c = seq[(n - 1) / CPB];
            chk("serial", 32'(serial[id]), (c == "1") ? 32'd1 : 32'd0);
            chk("done", 32'(done[id]), (n == f) ? 32'd1 : 32'd0);
            if (abort_at > 0 && n == abort_at) begin
                reset = 1'b1;
                @(posedge clka);
                @(negedge clka);
                reset = 1'b0;
                chk("abort_serial", 32'(serial[id]), 32'd1);
                chk("abort_ready", 32'(ready[id]), 32'd1);
                chk("abort_busy", 32'(busy[id]), 32'd0);
                chk("abort_out", 32'(out[id]), 32'h00);
                chk("abort_done", 32'(done[id]), 32'd0);
                return;
            end
            if (n == f) begin
                chk("ready_done", 32'(ready[id]), 32'd1);
                chk("busy_done", 32'(busy[id]), 32'd0);
                chk("out_done", 32'(out[id]), 32'(exp_out));
            end
        end
    endtask

    // Idle window: the line must stay high and tx_done must not pulse.
    task automatic idle(input int id, input int cycles);
        int pulses = 0;
        int highs  = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clka);
            if (done[id] === 1'b1) pulses++;
            if (serial[id] === 1'b1) highs++;
        end
        chk("idle_done_pulses", 32'(pulses), 32'd0);
        chk("idle_line_high", 32'(highs), 32'(cycles));
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start[i] = 1'b0;
            data[i]  = 8'h00;
        end
        // Request together with reset: reset must win.
        start[0] = 1'b1;
        data[0]  = 8'h5A;
        repeat (3) @(posedge clka);
        @(negedge clka);
        for (int i = 0; i < 4; i++) begin
            chk("rst_ready", 32'(ready[i]), 32'd1);
            chk("rst_serial", 32'(serial[i]), 32'd1);
            chk("rst_busy", 32'(busy[i]), 32'd0);
            chk("rst_done", 32'(done[i]), 32'd0);
            chk("rst_out", 32'(out[i]), 32'h00);
        end
        start[0] = 1'b0;
        reset    = 1'b0;
        idle(0, 4);
        chk("rst_wins_out", 32'(out[0]), 32'h00);

        // Basic 8N1 frame of A5.
        send(0, 8'hA5, "0101001011", 8'hA5, 1'b0, 8'h00, 0, 8'h00, 0);
        idle(0, 5);

        // 07 with even then odd parity.
        send(1, 8'h07, "01110000011", 8'h07, 1'b0, 8'h00, 0, 8'h00, 0);
        idle(1, 3);
        send(2, 8'h07, "01110000001", 8'h07, 1'b0, 8'h00, 0, 8'h00, 0);
        idle(2, 3);

        // Back-to-back: 00 with start held (next byte FF) through the done cycle.
        send(0, 8'h00, "0000000001", 8'h00, 1'b1, 8'hFF, 0, 8'h00, 0);
        send(0, 8'hFF, "0111111111", 8'hFF, 1'b0, 8'h00, 0, 8'h00, 0);
        idle(0, 20);

        // Busy ignore: 3C poked at cycle 40 of an 81 frame.
        send(0, 8'h81, "0100000011", 8'h81, 1'b0, 8'h00, 40, 8'h3C, 0);
        idle(0, 200);
        chk("busy_ignore_out", 32'(out[0]), 32'h81);

        // Reset during data bit 3 of F0, then a clean 55 frame.
        send(0, 8'hF0, "0000011111", 8'hF0, 1'b0, 8'h00, 0, 8'h00, 70);
        idle(0, 200);
        send(0, 8'h55, "0101010101", 8'h55, 1'b0, 8'h00, 0, 8'h00, 0);
        idle(0, 5);

        // 5 data bits: upper bits masked off.
        send(3, 8'hFF, "0111111", 8'h1F, 1'b0, 8'h00, 0, 8'h00, 0);
        idle(3, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Upstream transmit stage of the UART datapath. It accepts a parallel byte over a valid/ready handshake and serializes it onto a single line: start bit, data LSB-first, optional parity, stop bit. It also publishes the byte (tx_out) and a one-cycle tx_done pulse, which the downstream capture latch uses as its enable. Single clock domain, clka.

Parameters:
CLKS_PER_BIT, 16, clka cycles per serial bit; legal range >= 2.
DATA_BITS, 8, data bits per frame; legal range 5..8. tx_out is always 8 bits wide; unused MSBs are 0.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.

Ports:
clka  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
tx_start  input  1  request valid; a byte is accepted on an edge where tx_start && tx_ready.
tx_data  input  8  byte to send; sampled only on the accepting edge.
tx_ready  output  1  high iff state == IDLE.
tx_serial  output  1  serial line; idles high; registered output.
tx_busy  output  1  high in START, DATA, PARITY and STOP.
tx_done  output  1  one-cycle pulse when a frame completes.
tx_out  output  8  the byte most recently accepted; holds until the next accept.

Behaviour:
- Reset (synchronous): state=IDLE, tx_serial=1, tx_busy=0, tx_done=0, tx_out=8'h00, tx_ready=1, baud and bit counters=0. Reset takes effect at the next edge even mid-frame; the partial frame is abandoned and no tx_done is produced.
- States and transitions: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
- Accept edge:
  - shift_reg <= tx_data; tx_out <= tx_data (upper bits masked per DATA_BITS).
  - Parity register <= XOR of the masked data, inverted if PARITY_ODD.
  - State -> START; tx_serial = 0 starting the cycle after the accept edge (latency 1).
- Bit timing:
  - The baud counter counts 0..CLKS_PER_BIT-1. Each bit is held exactly CLKS_PER_BIT cycles; no jitter and no gaps between bits.
  - DATA: shift right on each bit boundary; the bit counter runs 0..DATA_BITS-1. Transition to the next state when bit counter == DATA_BITS-1 and baud counter wraps.
  - STOP: tx_serial = 1 for CLKS_PER_BIT cycles.
- Frame length: F = (2 + DATA_BITS + PARITY_EN) * CLKS_PER_BIT cycles.
- tx_done:
  - High for exactly one cycle, in the cycle where state returns to IDLE, i.e. F cycles after the accept edge.
  - tx_ready is high in that same cycle.
  - tx_out is stable and valid whenever tx_done = 1.
- Back-to-back: tx_start held high in the tx_done cycle is accepted. The next start bit directly follows the stop bit with zero idle cycles.
- tx_start while busy is ignored. No queuing; tx_data changes mid-frame have no effect.
- tx_start and reset in the same cycle: reset wins.
- Counters are sized ceil(log2(CLKS_PER_BIT)) and 3 bits respectively. No counter may wrap outside the defined ranges.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (IDLE, START, DATA, PARITY, STOP; 3-bit),
  - default constants UART_CLKS_PER_BIT and UART_DATA_BITS,
  - the parity function, which is reused by the receiver.
- One sub-module, uart_baud_gen:
  - Free-running tick counter with a synchronous clear (asserted on accept) and a single output, bit_tick.
  - The FSM, shift register and parity logic stay in uart_tx_serializer.

Test Plan:
- Basic frame: CLKS_PER_BIT=16, tx_data=8'hA5, single tx_start pulse.
  - Required response: tx_serial per 16-cycle bit: 0,1,0,1,0,0,1,0,1,1.
  - tx_done pulses exactly 160 cycles after the accept edge; tx_out=8'hA5.
- Parity: PARITY_EN=1, tx_data=8'h07.
  - Even parity: parity bit = 1, frame length 176 cycles.
  - PARITY_ODD=1: parity bit = 0.
- Back-to-back: send 8'h00, then hold tx_start with 8'hFF through the tx_done cycle.
  - Stop bit of frame 1 is immediately followed by the start bit of frame 2.
  - Exactly two tx_done pulses, 160 cycles apart; tx_out goes 00 -> FF at the second accept.
- Busy ignore: pulse tx_start with 8'h3C at cycle 40 of an 8'h81 frame.
  - Line shows only 8'h81; tx_out stays 8'h81; exactly one tx_done.
- Reset mid-frame: assert reset during DATA bit 3 of 8'hF0.
  - At the next edge: tx_serial=1, tx_ready=1, tx_out=00, and tx_done never pulses.
  - A subsequent 8'h55 frame transmits correctly.
- DATA_BITS=5: tx_data=8'hFF.
  - 5 data bits of 1 on the line, frame length 112 cycles, tx_out=8'h1F.
